// File: rtl/operand_entry_pkg.sv
// rtl/operand_entry_pkg.sv - shared key codes, FSM states and constants for keypad operand entry
package operand_entry_pkg;

    typedef enum logic [2:0] {
        KEY_DIGIT = 3'b000,
        KEY_ENTER = 3'b001,
        KEY_PLUS  = 3'b010,
        KEY_CLEAR = 3'b011,
        KEY_MINUS = 3'b100,
        KEY_BKSP  = 3'b101
    } key_class_e;

    typedef enum logic {
        ENTRY = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int DEC_BASE = 10;

endpackage

// File: rtl/decimal_accumulator.sv
// rtl/decimal_accumulator.sv - signed decimal digit accumulator with range and digit-count limits
//   clk, rst      : clock, async active-low reset
//   op_*          : one-hot key strobes (op_clear has priority)
//   digit_value   : decimal digit 0..9 for op_digit
//   value         : neg ? -mag : mag (combinational)
//   digit_count   : digits held in the current entry
//   reject        : combinational strobe, the current key is refused
module decimal_accumulator
    import operand_entry_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int MAX_DIGITS = 3,
    localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_digit,
    input  logic             op_minus,
    input  logic             op_plus,
    input  logic             op_bksp,
    input  logic             op_clear,
    input  logic [3:0]       digit_value,
    output logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] digit_count,
    output logic             reject
);

    // Extra 4 bits so mag*10+9 can never wrap before the limit compare.
    localparam int CAND_W = WIDTH + 4;
    localparam logic [CAND_W-1:0] NEG_LIMIT = CAND_W'(1) << (WIDTH - 1);
    localparam logic [CAND_W-1:0] POS_LIMIT = NEG_LIMIT - CAND_W'(1);

    logic [WIDTH-1:0]  mag;
    logic              neg;
    logic [CAND_W-1:0] cand;
    logic [CAND_W-1:0] limit;
    logic              digit_reject;
    logic              plus_reject;

    assign cand         = CAND_W'(mag) * CAND_W'(DEC_BASE) + CAND_W'(digit_value);
    assign limit        = neg ? NEG_LIMIT : POS_LIMIT;
    assign digit_reject = op_digit && ((digit_count == CNT_W'(MAX_DIGITS)) || (cand > limit));
    // The most negative magnitude has no positive counterpart, so the sign must stay.
    assign plus_reject  = op_plus && (mag == NEG_LIMIT[WIDTH-1:0]);
    assign reject       = digit_reject || plus_reject;
    assign value        = neg ? -mag : mag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag         <= '0;
            neg         <= 1'b0;
            digit_count <= '0;
        end else if (op_clear) begin
            mag         <= '0;
            neg         <= 1'b0;
            digit_count <= '0;
        end else if (op_digit) begin
            if (!digit_reject) begin
                mag         <= cand[WIDTH-1:0];
                digit_count <= digit_count + CNT_W'(1);
            end
        end else if (op_minus) begin
            neg <= 1'b1;
        end else if (op_plus) begin
            if (!plus_reject) begin
                neg <= 1'b0;
            end
        end else if (op_bksp) begin
            if (digit_count != '0) begin
                mag         <= mag / WIDTH'(DEC_BASE);
                digit_count <= digit_count - CNT_W'(1);
            end else begin
                neg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/operand_entry_bank.sv
// rtl/operand_entry_bank.sv - keypad operand entry bank with valid/ready release of the operand set
//   clk, rst        : clock, async active-low reset
//   key_value       : digit value for DIGIT keys
//   key_pressed     : debounced key level, rising edge is one event
//   key_class       : key code (operand_entry_pkg::key_class_e)
//   ops_ready       : consumer accepts the operand set
//   operands        : packed operands, operand k at [k*WIDTH +: WIDTH]
//   ops_valid       : operand set complete and held
//   temp_value      : signed value under entry (combinational)
//   digit_count     : digits in the current entry
//   active_idx      : operand being entered
//   overflow        : one-cycle pulse per rejected key
module operand_entry_bank
    import operand_entry_pkg::*;
#(
    parameter  int WIDTH        = 8,
    parameter  int NUM_OPERANDS = 2,
    parameter  int MAX_DIGITS   = 3,
    localparam int IDX_W        = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1,
    localparam int CNT_W        = $clog2(MAX_DIGITS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    key_value,
    input  logic                          key_pressed,
    input  logic [2:0]                    key_class,
    input  logic                          ops_ready,
    output logic [NUM_OPERANDS*WIDTH-1:0] operands,
    output logic                          ops_valid,
    output logic [WIDTH-1:0]              temp_value,
    output logic [CNT_W-1:0]              digit_count,
    output logic [IDX_W-1:0]              active_idx,
    output logic                          overflow
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPERANDS - 1);

    state_e state;
    logic   key_prev;
    logic   key_event;
    logic   entry_event;
    logic   ev_clear;
    logic   ev_enter;
    logic   acc_digit;
    logic   acc_minus;
    logic   acc_plus;
    logic   acc_bksp;
    logic   acc_clear;
    logic   acc_reject;

    assign key_event   = key_pressed && !key_prev;
    assign ev_clear    = key_event && (key_class == KEY_CLEAR);
    // Only CLEAR acts in HOLD; this gating also drops any key coinciding with acceptance.
    assign entry_event = key_event && (state == ENTRY);
    assign ev_enter    = entry_event && (key_class == KEY_ENTER);
    assign acc_digit   = entry_event && (key_class == KEY_DIGIT) && (key_value <= 4'd9);
    assign acc_minus   = entry_event && (key_class == KEY_MINUS);
    assign acc_plus    = entry_event && (key_class == KEY_PLUS);
    assign acc_bksp    = entry_event && (key_class == KEY_BKSP);
    assign acc_clear   = ev_clear || ev_enter;

    decimal_accumulator #(
        .WIDTH      (WIDTH),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .op_digit    (acc_digit),
        .op_minus    (acc_minus),
        .op_plus     (acc_plus),
        .op_bksp     (acc_bksp),
        .op_clear    (acc_clear),
        .digit_value (key_value),
        .value       (temp_value),
        .digit_count (digit_count),
        .reject      (acc_reject)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ENTRY;
            key_prev   <= 1'b0;
            operands   <= '0;
            ops_valid  <= 1'b0;
            active_idx <= '0;
            overflow   <= 1'b0;
        end else begin
            key_prev <= key_pressed;
            overflow <= acc_reject;
            if (ev_clear) begin
                state      <= ENTRY;
                operands   <= '0;
                ops_valid  <= 1'b0;
                active_idx <= '0;
            end else if (state == HOLD) begin
                if (ops_valid && ops_ready) begin
                    state      <= ENTRY;
                    ops_valid  <= 1'b0;
                    active_idx <= '0;
                end
            end else if (ev_enter) begin
                for (int k = 0; k < NUM_OPERANDS; k++) begin
                    if (active_idx == IDX_W'(k)) begin
                        operands[k*WIDTH +: WIDTH] <= temp_value;
                    end
                end
                if (active_idx == LAST_IDX) begin
                    state     <= HOLD;
                    ops_valid <= 1'b1;
                end else begin
                    active_idx <= active_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_entry_bank.sv
// tb/tb_operand_entry_bank.sv - scoreboard bench for operand_entry_bank (8b x2 and 12b x3 builds)
module tb_operand_entry_bank;

    localparam logic [2:0] K_DIGIT = 3'b000;
    localparam logic [2:0] K_ENTER = 3'b001;
    localparam logic [2:0] K_PLUS  = 3'b010;
    localparam logic [2:0] K_CLEAR = 3'b011;
    localparam logic [2:0] K_MINUS = 3'b100;
    localparam logic [2:0] K_BKSP  = 3'b101;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] key_value = '0;
    logic [2:0] key_class = '0;
    logic       key_pressed = 1'b0;
    logic       ops_ready = 1'b0;
    logic       tgt = 1'b0;

    logic kp1, kp2, rdy1, rdy2;
    assign kp1  = key_pressed & ~tgt;
    assign kp2  = key_pressed & tgt;
    assign rdy1 = ops_ready & ~tgt;
    assign rdy2 = ops_ready & tgt;

    logic [15:0] operands1;
    logic        ops_valid1;
    logic [7:0]  temp1;
    logic [1:0]  cnt1;
    logic        idx1;
    logic        ovf1;

    logic [35:0] operands2;
    logic        ops_valid2;
    logic [11:0] temp2;
    logic [2:0]  cnt2;
    logic [1:0]  idx2;
    logic        ovf2;

    operand_entry_bank #(.WIDTH(8), .NUM_OPERANDS(2), .MAX_DIGITS(3)) dut (
        .clk(clk), .rst(rst), .key_value(key_value), .key_pressed(kp1),
        .key_class(key_class), .ops_ready(rdy1), .operands(operands1),
        .ops_valid(ops_valid1), .temp_value(temp1), .digit_count(cnt1),
        .active_idx(idx1), .overflow(ovf1)
    );

    operand_entry_bank #(.WIDTH(12), .NUM_OPERANDS(3), .MAX_DIGITS(4)) dut2 (
        .clk(clk), .rst(rst), .key_value(key_value), .key_pressed(kp2),
        .key_class(key_class), .ops_ready(rdy2), .operands(operands2),
        .ops_valid(ops_valid2), .temp_value(temp2), .digit_count(cnt2),
        .active_idx(idx2), .overflow(ovf2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ovf_pending = 0;
    int ovf2_seen = 0;
    logic [15:0] exp1_q[$];
    logic [35:0] exp2_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Operand-set monitors: compare on each rising ops_valid.
    logic pv1 = 1'b0, pv2 = 1'b0, povf = 1'b0;
    always @(negedge clk) begin
        if (ops_valid1 && !pv1) begin
            if (exp1_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL set1_unexpected: got %0h expected none", operands1);
            end else begin
                chk("set1", 64'(operands1), 64'(exp1_q.pop_front()));
            end
        end
        if (ops_valid2 && !pv2) begin
            if (exp2_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL set2_unexpected: got %0h expected none", operands2);
            end else begin
                chk("set2", 64'(operands2), 64'(exp2_q.pop_front()));
            end
        end
        pv1 = ops_valid1;
        pv2 = ops_valid2;
    end

    // Overflow monitor: each pulse must match one expected rejection and last one cycle.
    always @(negedge clk) begin
        if (ovf1) begin
            if (povf) chk("ovf_width", 64'(1), 64'(0));
            checks++;
            if (ovf_pending == 0) begin
                errors++;
                $display("FAIL ovf_unexpected: got pulse expected none");
            end else begin
                ovf_pending--;
            end
        end
        povf = ovf1;
        if (ovf2) ovf2_seen++;
    end

    task automatic press(input logic [2:0] c, input logic [3:0] v, input bit rej,
                         input int hold, input bit rdy);
        if (rej) ovf_pending++;
        @(posedge clk); #1;
        key_class = c; key_value = v; key_pressed = 1'b1; ops_ready = rdy;
        repeat (hold) @(posedge clk);
        #1;
        key_pressed = 1'b0; ops_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic dig(input logic [3:0] v);
        press(K_DIGIT, v, 1'b0, 1, 1'b0);
    endtask

    task automatic key(input logic [2:0] c);
        press(c, 4'd0, 1'b0, 1, 1'b0);
    endtask

    task automatic accept();
        @(posedge clk); #1;
        ops_ready = 1'b1;
        @(posedge clk); #1;
        ops_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("reset1", {operands1, ops_valid1, idx1, temp1, cnt1, ovf1}, 64'(0));
        chk("reset2", {operands2, ops_valid2, idx2, temp2, cnt2, ovf2}, 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        // 127 into operand 0
        dig(1); dig(2); dig(7);
        chk("t1_temp", 64'(temp1), 64'h7F);
        chk("t1_cnt", 64'(cnt1), 64'd3);
        key(K_ENTER);
        chk("t1_op0", 64'(operands1[7:0]), 64'h7F);
        chk("t1_idx", 64'(idx1), 64'd1);

        // 128 rejected positive, accepted negative
        dig(1); dig(2);
        press(K_DIGIT, 4'd8, 1'b1, 1, 1'b0);
        chk("t2_temp12", 64'(temp1), 64'd12);
        key(K_MINUS); dig(8);
        chk("t2_temp_m128", 64'(temp1), 64'h80);
        exp1_q.push_back(16'h807F);
        key(K_ENTER);
        chk("t2_valid", 64'(ops_valid1), 64'd1);
        dig(5);
        chk("hold_digit_ignored", {temp1, cnt1}, 64'(0));
        accept();
        chk("t2_accept", {ops_valid1, idx1}, 64'(0));
        chk("t2_retained", 64'(operands1), 64'h807F);

        // PLUS at -128 rejected, sign kept
        key(K_MINUS); dig(1); dig(2); dig(8);
        press(K_PLUS, 4'd0, 1'b1, 1, 1'b0);
        chk("t2_plus_rej", 64'(temp1), 64'h80);
        key(K_ENTER);
        chk("t2_op0_neg", 64'(operands1[7:0]), 64'h80);
        dig(9); dig(9);
        key(K_CLEAR);
        chk("t5_clear_mid", {operands1, ops_valid1, idx1, temp1, cnt1}, 64'(0));

        // held key yields a single digit; illegal digit ignored; backspace rules
        press(K_DIGIT, 4'd7, 1'b0, 5, 1'b0);
        chk("held_key", {temp1, cnt1}, {8'd7, 2'd1});
        dig(4'd12);
        chk("digit_gt9", {temp1, cnt1}, {8'd7, 2'd1});
        key(K_BKSP);
        chk("bksp_last", {temp1, cnt1}, 64'(0));
        key(K_MINUS); key(K_BKSP); dig(5);
        chk("bksp_clears_neg", 64'(temp1), 64'd5);
        key(K_CLEAR);
        dig(0); dig(0); dig(1);
        press(K_DIGIT, 4'd2, 1'b1, 1, 1'b0);
        chk("max_digits", {temp1, cnt1}, {8'd1, 2'd3});
        key(K_CLEAR);

        // -47 and 3
        dig(4); dig(5); key(K_BKSP);
        chk("t3_bksp", {temp1, cnt1}, {8'd4, 2'd1});
        dig(7); key(K_MINUS); key(K_ENTER);
        dig(3);
        exp1_q.push_back(16'h03D1);
        key(K_ENTER);
        chk("t3_valid", 64'(ops_valid1), 64'd1);
        dig(6);
        chk("t3_hold_ignored", {operands1, temp1, cnt1}, {16'h03D1, 8'd0, 2'd0});

        // hold with ops_ready low, then accept
        begin
            bit stable = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (ops_valid1 !== 1'b1 || operands1 !== 16'h03D1) stable = 1'b0;
            end
            chk("t4_stable", 64'(stable), 64'd1);
        end
        accept();
        chk("t4_accept", {ops_valid1, idx1, operands1}, {1'b0, 1'b0, 16'h03D1});

        // CLEAR together with ops_ready in HOLD
        dig(1); key(K_ENTER); dig(2);
        exp1_q.push_back(16'h0201);
        key(K_ENTER);
        press(K_CLEAR, 4'd0, 1'b0, 1, 1'b1);
        chk("t5_clear_hold", {operands1, ops_valid1, idx1}, 64'(0));

        // asynchronous reset mid-cycle in HOLD
        dig(9); key(K_ENTER); dig(9);
        exp1_q.push_back(16'h0909);
        key(K_ENTER);
        chk("t6_in_hold", 64'(ops_valid1), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_rst", {operands1, ops_valid1, idx1, temp1, cnt1, ovf1}, 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        // 12-bit, three-operand build
        tgt = 1'b1;
        dig(2); dig(0); dig(4); dig(7);
        chk("w12_temp_max", {temp2, cnt2}, {12'h7FF, 3'd4});
        key(K_ENTER);
        key(K_MINUS); dig(2); dig(0); dig(4); dig(8);
        chk("w12_temp_min", 64'(temp2), 64'h800);
        key(K_ENTER);
        chk("w12_idx2", 64'(idx2), 64'd2);
        exp2_q.push_back(36'h0008007FF);
        key(K_ENTER);
        chk("w12_valid", {ops_valid2, idx2}, {1'b1, 2'd2});
        accept();
        chk("w12_accept", {ops_valid2, idx2, operands2}, {1'b0, 2'd0, 36'h0008007FF});
        tgt = 1'b0;

        repeat (3) @(posedge clk);
        chk("ovf_all_seen", 64'(ovf_pending), 64'd0);
        chk("ovf2_none", 64'(ovf2_seen), 64'd0);
        chk("set1_drained", 64'(exp1_q.size()), 64'd0);
        chk("set2_drained", 64'(exp2_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_entry_bank.md
Name: operand_entry_bank

Overview:
Parametrised keypad operand-entry block for the Booth multiplier datapath. It turns debounced keypad events into NUM_OPERANDS signed two's-complement operands of WIDTH bits:
- decimal digit accumulation with per-operand sign;
- range and digit-count checking with an overflow flag;
- backspace and clear;
- a valid/ready handshake that releases the completed operand set to the multiplier control.

It sits between the keypad scanner/debouncer and the multiplier FSM, and also drives the display path.

Parameters:
WIDTH, 8, operand width in bits, signed two's complement (>=4)
NUM_OPERANDS, 2, number of operands captured per transaction (>=1)
MAX_DIGITS, 3, maximum decimal digits accepted per operand
IDX_W, $clog2(NUM_OPERANDS) min 1, operand index width (derived)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset; asynchronous, active-low
key_value  in  4  digit value, meaningful when key_class=DIGIT
key_pressed  in  1  level, debounced and synchronous to clk; event = rising edge
key_class  in  3  DIGIT=000, ENTER=001, PLUS=010, CLEAR=011, MINUS=100, BKSP=101; others ignored
ops_ready  in  1  consumer accepts operand set
operands  out  NUM_OPERANDS*WIDTH  packed operands, operand k at bits [k*WIDTH +: WIDTH]
ops_valid  out  1  operand set complete and held
temp_value  out  WIDTH  signed value under entry (neg ? -mag : mag), for display
digit_count  out  $clog2(MAX_DIGITS+1)  digits in current entry
active_idx  out  IDX_W  operand currently being entered
overflow  out  1  one-cycle pulse on rejected key

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - operands, temp_value, digit_count, active_idx = 0;
  - ops_valid = 0, overflow = 0;
  - internal mag = 0, neg = 0, key_prev = 0, state = ENTRY.
  - Reset mid-entry or mid-handshake discards everything.
- Edge detect: key_prev <= key_pressed every cycle. An event is key_pressed & !key_prev. Its effect is visible on the outputs on the following cycle (1-cycle latency). Holding the key produces one event only.
- The state machine has two states, ENTRY and HOLD.
- ENTRY, DIGIT event:
  - key_value > 9: ignored, no overflow.
  - Otherwise cand = mag*10 + key_value, computed at WIDTH+4 bits. The limit is 2^(WIDTH-1)-1 if neg=0, else 2^(WIDTH-1).
  - If digit_count == MAX_DIGITS or cand > limit: reject the key; mag and digit_count are unchanged and overflow pulses.
  - Otherwise mag <= cand and digit_count++.
  - Leading zeros count as digits.
- ENTRY, MINUS: neg <= 1.
- ENTRY, PLUS: neg <= 0. Exception: if mag == 2^(WIDTH-1), reject and pulse overflow.
- ENTRY, BKSP:
  - digit_count > 0: mag <= mag/10 and digit_count--. neg is retained.
  - digit_count == 0: neg <= 0.
- ENTRY, ENTER:
  - Commit: operands[active_idx] <= neg ? -mag : mag.
  - Clear mag, neg and digit_count.
  - ENTER with no digits commits 0.
  - If active_idx == NUM_OPERANDS-1: state <= HOLD, ops_valid <= 1, active_idx unchanged. Otherwise active_idx++.
- CLEAR (either state):
  - operands, mag, neg, digit_count and active_idx go to 0; ops_valid <= 0; state <= ENTRY.
  - CLEAR wins over a same-cycle ops_ready.
- HOLD:
  - All events except CLEAR are ignored, with no overflow.
  - On ops_valid & ops_ready (and no CLEAR event): ops_valid <= 0, active_idx <= 0, state <= ENTRY. Operands are retained until overwritten.
  - ops_valid stays high until accepted. ops_ready while ops_valid=0 has no effect.
- An event in the same cycle as the handshake acceptance is ignored; it is not carried into ENTRY.
- overflow is registered, high for exactly one cycle per rejected event.
- All outputs are registered except temp_value, which is combinational from mag/neg.

Decomposition:
- Package operand_entry_pkg:
  - key_class_e enum (the 3-bit codes above);
  - state_e {ENTRY, HOLD};
  - constant DEC_BASE=10.
- Sub-module decimal_accumulator, parametrised by WIDTH and MAX_DIGITS. It owns mag, neg and digit_count; implements digit/sign/backspace/clear with limit checking; outputs the signed value and a reject strobe.
- operand_entry_bank owns edge detection, the FSM, the operand registers, active_idx and the handshake.

Test Plan:
1. WIDTH=8: keys 1,2,7,ENTER -> operands[0]=0x7F, active_idx=1, overflow never high.
2. Keys 1,2,8 -> 8 rejected, overflow pulses 1 cycle, temp_value=12. Then MINUS,8,ENTER -> operand=-128 (0x80). Repeat with MINUS,1,2,8,PLUS -> PLUS rejected, overflow pulses.
3. Keys 4,5,BKSP,7,MINUS,ENTER then 3,ENTER -> operands[0]=-47 (0xD1), operands[1]=3, ops_valid=1 one cycle after last ENTER. Digit keys in HOLD are ignored.
4. Handshake: ops_ready held low 10 cycles -> ops_valid stays 1 and operands are stable. Raise ops_ready -> ops_valid=0 and active_idx=0 next cycle, operands retained.
5. CLEAR mid-entry of operand 1, and CLEAR together with ops_ready in HOLD -> all operands 0, active_idx=0, ops_valid=0. Holding key_pressed for 5 cycles yields one digit only.
6. Assert rst asynchronously mid-cycle during HOLD -> all outputs 0 immediately. Then NUM_OPERANDS=3 / WIDTH=12 build: entering 2047, -2048 and 0 yields 0x7FF, 0x800, 0x000 with ops_valid.
